// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

    localparam int              STRB_W    = 4;
    localparam logic [STRB_W-1:0] STRB_NONE = 4'b0000;
    // Wide enough for MAX_WAIT up to 15.
    localparam int              STARVE_W  = 4;

endpackage

// File: rtl/arb_priority_sel.sv
// Idle-state winner select: the data port wins unless fetch has already lost
// MAX_WAIT consecutive arbitrations while requesting.
module arb_priority_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                if_req,
    input  logic                dm_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_vld,
    output owner_e              winner
);

    logic if_forced;

    assign if_forced = if_req && (starve_cnt == STARVE_W'(MAX_WAIT));
    assign grant_vld = if_req || dm_req;
    assign winner    = (dm_req && !if_forced) ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Define MEM_ARB_PERF_EN to add the perf_if_wait / perf_dm_wait stall-cycle counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [STRB_W-1:0] dm_wstrb,
    output logic              dm_rsp_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_dm_wait
`endif
);

    arb_state_e          state_q;
    owner_e              owner_q;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]   mem_wstrb_q;
    logic                if_rsp_valid_q, dm_rsp_valid_q;
    logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
    logic                grant_vld;
    owner_e              winner;

    arb_priority_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .starve_cnt (starve_q),
        .grant_vld  (grant_vld),
        .winner     (winner)
    );

    // Starvation count only moves at IDLE decisions, but any idle fetch port clears it.
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if (state_q == IDLE && grant_vld) begin
            if (winner == OWN_IF) begin
                starve_d = '0;
            end else if (starve_q != STARVE_W'(MAX_WAIT)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IF;
            starve_q       <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= STRB_NONE;
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            if_rdata_q     <= '0;
            dm_rdata_q     <= '0;
        end else begin
            starve_q       <= starve_d;
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q   <= winner;
                        mem_req_q <= 1'b1;
                        state_q   <= ISSUE;
                        if (winner == OWN_DM) begin
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_we ? dm_wdata : '0;
                            mem_wstrb_q <= dm_we ? dm_wstrb : STRB_NONE;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= STRB_NONE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rvalid) begin
                        state_q <= RESP;
                        if (owner_q == OWN_DM) begin
                            dm_rdata_q     <= mem_we_q ? '0 : mem_rdata;
                            dm_rsp_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q     <= mem_rdata;
                            if_rsp_valid_q <= 1'b1;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign if_rsp_valid = if_rsp_valid_q;
    assign dm_rsp_valid = dm_rsp_valid_q;
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign if_stall     = if_req & ~if_rsp_valid_q;
    assign dm_stall     = dm_req & ~dm_rsp_valid_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_dm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q <= '0;
            perf_dm_q <= '0;
        end else begin
            if (if_stall) perf_if_q <= perf_if_q + 32'd1;
            if (dm_stall) perf_dm_q <= perf_dm_q + 32'd1;
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_dm_wait = perf_dm_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model
// and a behavioural memory with configurable grant / response delays.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dcmd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_rsp_valid, if_stall;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we, dm_rsp_valid, dm_stall;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic [3:0]        dm_wstrb;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [3:0]        mem_wstrb;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_if_wait, perf_dm_wait;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rdata     (if_rdata),
        .if_stall     (if_stall),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_wstrb     (dm_wstrb),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rdata     (dm_rdata),
        .dm_stall     (dm_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    logic [31:0] phys_mem [64];
    logic [31:0] ref_mem  [64];

    logic [31:0] if_q [$];
    dcmd_t       dm_q [$];
    dcmd_t       dm_cmd;
    int          if_st, dm_st;
    int          if_rand, dm_rand;
    bit          spur_en;
    int          gnt_lo, gnt_hi, rv_lo, rv_hi;

    int          mphase, mcnt;
    logic        snap_we;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_wstrb;

    bit          rsp_pend, rsp_next, arb_idle, exp_issue;
    int          rsp_own, infl_own, losses, cyc;
    logic [31:0] infl_data;

    int          if_req_cyc, if_rsp_cyc, n_rsp, stall_if_total;
    logic [31:0] last_if_data, last_dm_data;
    logic        we_log [$];
    logic [3:0]  strb_log [$];
    int          n_if_perf, n_dm_perf;

    task automatic model_init();
        mphase = 0; mcnt = 0; rsp_pend = 0; rsp_next = 0;
        arb_idle = 1; exp_issue = 0; losses = 0;
        if_st = 0; dm_st = 0;
        if_q.delete(); dm_q.delete();
        n_if_perf = 0; n_dm_perf = 0;
        if_req = 0; dm_req = 0; mem_gnt = 0; mem_rvalid = 0;
    endtask

    // One clock of the reference: observe Q(t) at negedge, then drive I(t).
    task automatic step();
        bit rif, rdm, new_issue, dm_win, anyr;
        @(negedge clk);
        cyc++;
`ifdef MEM_ARB_PERF_EN
        chk("perf_if_wait", perf_if_wait, n_if_perf);
        chk("perf_dm_wait", perf_dm_wait, n_dm_perf);
`endif
        rif = rsp_pend && rsp_own == 0;
        rdm = rsp_pend && rsp_own == 1;
        chk("if_rsp_valid", if_rsp_valid, rif);
        chk("dm_rsp_valid", dm_rsp_valid, rdm);
        if (rif) chk("if_rdata", if_rdata, infl_data);
        if (rdm) chk("dm_rdata", dm_rdata, infl_data);
        if (if_rsp_valid) begin n_rsp++; if_rsp_cyc = cyc; last_if_data = if_rdata; end
        if (dm_rsp_valid) begin n_rsp++; last_dm_data = dm_rdata; end

        new_issue = mem_req && mphase == 0;
        chk("issue_timing", new_issue, exp_issue);
        if (new_issue) begin
            dm_win = dm_req && !(if_req && losses == MAX_WAIT);
            if (dm_win) begin
                chk("dm_cmd_we", mem_we, dm_cmd.we);
                chk("dm_cmd_addr", mem_addr, dm_cmd.addr);
                chk("dm_cmd_wstrb", mem_wstrb, dm_cmd.we ? dm_cmd.wstrb : 4'h0);
                if (dm_cmd.we) begin
                    chk("dm_cmd_wdata", mem_wdata, dm_cmd.wdata);
                    ref_mem[dm_cmd.addr[7:2]] = merge(ref_mem[dm_cmd.addr[7:2]], dm_cmd.wdata,
                                                      dm_cmd.wstrb);
                    infl_data = 32'h0;
                end else begin
                    infl_data = ref_mem[dm_cmd.addr[7:2]];
                end
                infl_own = 1;
                if (if_req) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
                else losses = 0;
            end else begin
                chk("if_cmd_we", mem_we, 1'b0);
                chk("if_cmd_addr", mem_addr, if_addr);
                chk("if_cmd_wstrb", mem_wstrb, 4'h0);
                infl_data = ref_mem[if_addr[7:2]];
                infl_own  = 0;
                losses    = 0;
            end
            we_log.push_back(mem_we);
            strb_log.push_back(mem_wstrb);
            snap_we = mem_we; snap_addr = mem_addr; snap_wdata = mem_wdata; snap_wstrb = mem_wstrb;
            mphase = 1;
            mcnt   = $urandom_range(gnt_lo, gnt_hi);
        end else if (mphase == 1) begin
            chk("hold_req", mem_req, 1'b1);
            chk("hold_addr", mem_addr, snap_addr);
            chk("hold_wdata", mem_wdata, snap_wdata);
            chk("hold_we", mem_we, snap_we);
            chk("hold_wstrb", mem_wstrb, snap_wstrb);
        end else if (mphase == 2) begin
            chk("req_dropped", mem_req, 1'b0);
        end

        // Memory side
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom; rsp_next = 0;
        if (mphase == 1) begin
            if (mcnt == 0) begin
                mem_gnt = 1;
                if (snap_we)
                    phys_mem[snap_addr[7:2]] = merge(phys_mem[snap_addr[7:2]], snap_wdata, snap_wstrb);
                mphase = 2;
                mcnt   = $urandom_range(rv_lo, rv_hi);
            end else begin
                mcnt--;
                if (spur_en && $urandom_range(0, 9) == 0) mem_rvalid = 1;
            end
        end else if (mphase == 2) begin
            mcnt--;
            if (mcnt == 0) begin
                mem_rvalid = 1;
                if (!snap_we) mem_rdata = phys_mem[snap_addr[7:2]];
                rsp_next = 1;
                rsp_own  = infl_own;
                mphase   = 0;
            end
        end else if (spur_en) begin
            if ($urandom_range(0, 9) == 0) mem_rvalid = 1;
            if ($urandom_range(0, 9) == 0) mem_gnt = 1;
        end

        // Requesters: hold through the response cycle, then maybe issue anew.
        if (if_st == 1 && rif) begin
            if_st = 2;
        end else if (if_st != 1) begin
            if (if_q.size() > 0) begin
                if_addr = if_q.pop_front(); if_req = 1; if_st = 1; if_req_cyc = cyc;
            end else if ($urandom_range(0, 99) < if_rand) begin
                if_addr = 32'($urandom_range(0, 63)) << 2; if_req = 1; if_st = 1; if_req_cyc = cyc;
            end else begin
                if_req = 0; if_st = 0;
            end
        end
        if (dm_st == 1 && rdm) begin
            dm_st = 2;
        end else if (dm_st != 1) begin
            if (dm_q.size() > 0) begin
                dm_cmd = dm_q.pop_front(); dm_req = 1; dm_st = 1;
            end else if ($urandom_range(0, 99) < dm_rand) begin
                dm_cmd.we    = 1'($urandom_range(0, 1));
                dm_cmd.addr  = 32'($urandom_range(0, 63)) << 2;
                dm_cmd.wdata = $urandom;
                dm_cmd.wstrb = 4'($urandom_range(0, 15));
                dm_req = 1; dm_st = 1;
            end else begin
                dm_req = 0; dm_st = 0;
            end
        end
        dm_we = dm_cmd.we; dm_addr = dm_cmd.addr; dm_wdata = dm_cmd.wdata; dm_wstrb = dm_cmd.wstrb;

        anyr      = if_req || dm_req;
        exp_issue = arb_idle && anyr;
        arb_idle  = rif || rdm || (arb_idle && !anyr);
        if (!if_req) losses = 0;
        rsp_pend  = rsp_next;

        #1;
        chk("if_stall", if_stall, if_req && !rif);
        chk("dm_stall", dm_stall, dm_req && !rdm);
        if (if_req && !rif) n_if_perf++;
        if (dm_req && !rdm) n_dm_perf++;
        if (if_stall) stall_if_total++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_mem(input int gl, input int gh, input int rl, input int rh, input bit sp);
        gnt_lo = gl; gnt_hi = gh; rv_lo = rl; rv_hi = rh; spur_en = sp;
    endtask

    initial begin
        int s0, n0;
        for (int i = 0; i < 64; i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[0] = 32'h00500093;
        ref_mem[0]  = 32'h00500093;
        cyc = 0; n_rsp = 0; stall_if_total = 0;
        if_rand = 0; dm_rand = 0;
        if_addr = 0; dm_cmd = '0;
        dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0; mem_rdata = 0;
        set_mem(0, 0, 1, 1, 0);
        model_init();

        // Reset state
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wstrb", mem_wstrb, 4'h0);
        chk("rst_if_rsp", if_rsp_valid, 1'b0);
        chk("rst_dm_rsp", dm_rsp_valid, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        rst = 0;

        // Lone fetch, fastest memory
        s0 = stall_if_total;
        if_q.push_back(32'h0);
        run(8);
        chk("lone_latency", if_rsp_cyc - if_req_cyc, 3);
        chk("lone_rdata", last_if_data, 32'h00500093);
        chk("lone_stall_cycles", stall_if_total - s0, 3);

        // Store then read back
        strb_log.delete();
        dm_q.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'h0000000F, wstrb: 4'hF});
        dm_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, wstrb: 4'h0});
        run(15);
        chk("sl_count", strb_log.size(), 2);
        if (strb_log.size() >= 2) begin
            chk("sl_store_wstrb", strb_log[0], 4'hF);
            chk("sl_load_wstrb", strb_log[1], 4'h0);
        end
        chk("sl_readback", last_dm_data, 32'h0000000F);

        // Contention: both ports requesting continuously
        we_log.delete();
        for (int i = 0; i < 10; i++)
            dm_q.push_back('{we: 1'b1, addr: 32'(i) << 2, wdata: $urandom, wstrb: 4'hF});
        if_q.push_back(32'h40);
        if_q.push_back(32'h44);
        run(60);
        chk("cont_grants", we_log.size(), 12);
        for (int i = 0; i < 10 && i < we_log.size(); i++)
            chk($sformatf("cont_order_%0d", i), we_log[i], (i == 4 || i == 9) ? 1'b0 : 1'b1);

        // Slow memory: grant after 3 cycles, response 2 cycles later
        set_mem(3, 3, 2, 2, 0);
        n0 = n_rsp;
        dm_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hA5A55A5A, wstrb: 4'b0110});
        if_q.push_back(32'h20);
        run(30);
        chk("slow_pulses", n_rsp - n0, 2);

        // Randomized traffic with spurious gnt/rvalid
        set_mem(0, 3, 1, 3, 1);
        if_rand = 50; dm_rand = 50;
        run(1500);
        if_rand = 0; dm_rand = 0;
        run(40);

        // Reset while waiting for the memory response
        set_mem(0, 0, 3, 3, 0);
        dm_q.push_back('{we: 1'b0, addr: 32'h30, wdata: 32'h0, wstrb: 4'h0});
        for (int i = 0; i < 20 && mphase != 2; i++) step();
        chk("reach_wait_rsp", mphase == 2, 1'b1);
        @(negedge clk);
        rst = 1; if_req = 0; dm_req = 0; mem_gnt = 0; mem_rvalid = 0;
        @(negedge clk);
        chk("mrst_mem_req", mem_req, 1'b0);
        chk("mrst_dm_rsp", dm_rsp_valid, 1'b0);
        chk("mrst_dm_rdata", dm_rdata, 32'h0);
        rst = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("late_rv_dm_rsp", dm_rsp_valid, 1'b0);
        chk("late_rv_if_rsp", if_rsp_valid, 1'b0);
        chk("late_rv_mem_req", mem_req, 1'b0);
        mem_rvalid = 0;
        @(negedge clk);
        chk("late_rv_dm_rsp2", dm_rsp_valid, 1'b0);
        chk("late_rv_dm_rdata", dm_rdata, 32'h0);
        model_init();
        set_mem(0, 0, 1, 1, 0);
        if_q.push_back(32'h8);
        run(10);
        chk("post_rst_latency", if_rsp_cyc - if_req_cyc, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
